// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM slot constants and FSM state type
package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - 2-bit slot counter with enable, restart-to-1 and wrap flag
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    output logic [SLOT_W-1:0] cnt,
    output logic              wrap
);

    // Restart means the current sample is slot 0, so the next one is slot 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= SLOT_W'(1);
        end else if (en) begin
            cnt <= cnt + SLOT_W'(1);
        end
    end

    // The last slot of a frame is the one the counter currently points at.
    assign wrap = (cnt == SLOT_W'(SLOTS - 1));

endmodule

// File: rtl/tdm_demux1to4.sv
// rtl/tdm_demux1to4.sv - serial TDM stream to registered 4-channel frame demultiplexer
module tdm_demux1to4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_start,
    output logic [SLOTS*WIDTH-1:0] O,
    output logic                   out_valid,
    output logic [SLOT_W-1:0]      sel,
    output logic                   frame_err
);

    tdm_state_e        state_q;
    tdm_state_e        state_d;
    logic              run;
    logic              accept;
    logic              restart;
    logic              count_en;
    logic              wrap;
    logic              complete;
    logic              misplaced;
    logic [SLOT_W-1:0] slot_idx;
    logic [WIDTH-1:0]  sh0;
    logic [WIDTH-1:0]  sh1;
    logic [WIDTH-1:0]  sh2;

    assign run       = (state_q == ST_RUN);
    assign restart   = din_valid & frame_start;
    assign count_en  = din_valid & run;
    assign accept    = din_valid & (run | frame_start);
    assign slot_idx  = frame_start ? '0 : sel;
    // A frame_start on slot 3 aborts the frame, so it can never complete it.
    assign complete  = din_valid & run & ~frame_start & wrap;
    assign misplaced = din_valid & run & frame_start & (sel != '0);

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (count_en),
        .restart (restart),
        .cnt     (sel),
        .wrap    (wrap)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave IDLE on the first qualified frame_start; RUN free-runs afterwards.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_IDLE) && din_valid && frame_start) begin
            state_d = ST_RUN;
        end
    end

    // Shadow slots 0..2 collect the partial frame; slot 3 goes straight to O.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh0 <= '0;
            sh1 <= '0;
            sh2 <= '0;
        end else if (accept) begin
            case (slot_idx)
                2'd0:    sh0 <= din;
                2'd1:    sh1 <= din;
                2'd2:    sh2 <= din;
                default: ;
            endcase
        end
    end

    // Output frame and one-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            O         <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= complete;
            frame_err <= misplaced;
            if (complete) begin
                O <= {din, sh2, sh1, sh0};
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux1to4.sv
// tb/tb_tdm_demux1to4.sv - directed self-checking bench for tdm_demux1to4
module tb_tdm_demux1to4;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [3:0] O;
    logic       out_valid;
    logic [1:0] sel;
    logic       frame_err;

    int compared;
    int mismatched;
    int pulses;
    int errs;

    tdm_demux1to4 #(.WIDTH(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .O           (O),
        .out_valid   (out_valid),
        .sel         (sel),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic fs, input logic d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
        if (frame_err) errs++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        frame_start = 1'b0;
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        compared++; if (O !== 4'b0000) begin mismatched++; $display("FAIL reset_O got %b want 0000", O); end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        compared++; if (sel !== 2'd0) begin mismatched++; $display("FAIL reset_sel got %0d want 0", sel); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    endtask

    task automatic test_single_frame();
        logic [3:0] f;
        logic [1:0] exp_sel [4];
        exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
        f = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i == 0), f[i]);
            compared++; if (sel !== exp_sel[i]) begin mismatched++; $display("FAIL single_sel[%0d] got %0d want %0d", i, sel, exp_sel[i]); end
            compared++; if (out_valid !== (i == 3)) begin mismatched++; $display("FAIL single_out_valid[%0d] got %b want %b", i, out_valid, (i == 3)); end
        end
        compared++; if (O !== 4'b0101) begin mismatched++; $display("FAIL single_O got %b want 0101", O); end
        cyc(1'b0, 1'b0, 1'b0);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL single_strobe_len got %b want 0", out_valid); end
    endtask

    task automatic test_stall_free_run();
        logic [3:0] f;
        pulses = 0;
        f = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i == 0), f[i]);
            if (i == 1) begin
                compared++; if (O !== 4'b0101) begin mismatched++; $display("FAIL stall_O_hold got %b want 0101", O); end
            end
            if (i < 3) begin
                cyc(1'b0, 1'b1, 1'b1);
                cyc(1'b0, 1'b0, 1'b1);
                compared++; if (sel !== 2'(i + 1)) begin mismatched++; $display("FAIL stall_sel_hold[%0d] got %0d want %0d", i, sel, i + 1); end
            end
        end
        compared++; if (O !== 4'b0110) begin mismatched++; $display("FAIL stall_O got %b want 0110", O); end
        f = 4'b1000;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, f[i]);
        compared++; if (O !== 4'b1000) begin mismatched++; $display("FAIL freerun_O got %b want 1000", O); end
        cyc(1'b0, 1'b0, 1'b0);
        compared++; if (pulses !== 2) begin mismatched++; $display("FAIL stall_pulses got %0d want 2", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f;
        f = 8'b1100_0011;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, f[i]);
            compared++; if (out_valid !== (i == 3 || i == 7)) begin mismatched++; $display("FAIL b2b_out_valid[%0d] got %b want %b", i, out_valid, (i == 3 || i == 7)); end
            if (i == 3) begin
                compared++; if (O !== 4'b0011) begin mismatched++; $display("FAIL b2b_O0 got %b want 0011", O); end
            end
        end
        compared++; if (O !== 4'b1100) begin mismatched++; $display("FAIL b2b_O1 got %b want 1100", O); end
    endtask

    task automatic test_misplaced_start();
        pulses = 0;
        errs = 0;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL mis_frame_err got %b want 1", frame_err); end
        compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL mis_sel got %0d want 1", sel); end
        compared++; if (O !== 4'b1100) begin mismatched++; $display("FAIL mis_O_hold got %b want 1100", O); end
        cyc(1'b1, 1'b0, 1'b1);
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL mis_frame_err_len got %b want 0", frame_err); end
        cyc(1'b1, 1'b0, 1'b1);
        compared++; if (O !== 4'b1100) begin mismatched++; $display("FAIL mis_O_partial got %b want 1100", O); end
        cyc(1'b1, 1'b0, 1'b1);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL mis_out_valid got %b want 1", out_valid); end
        compared++; if (O !== 4'b1111) begin mismatched++; $display("FAIL mis_O got %b want 1111", O); end
        compared++; if (errs !== 1 || pulses !== 1) begin mismatched++; $display("FAIL mis_counts got err=%0d ov=%0d want 1/1", errs, pulses); end
    endtask

    task automatic test_slot3_abort();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        compared++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin mismatched++; $display("FAIL abort3_strobes got err=%b ov=%b want 1/0", frame_err, out_valid); end
        compared++; if (O !== 4'b1111) begin mismatched++; $display("FAIL abort3_O got %b want 1111", O); end
        compared++; if (sel !== 2'd1) begin mismatched++; $display("FAIL abort3_sel got %0d want 1", sel); end
    endtask

    task automatic test_idle_discard();
        do_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            compared++; if (sel !== 2'd0) begin mismatched++; $display("FAIL idle_sel[%0d] got %0d want 0", i, sel); end
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("FAIL idle_pulses got %0d want 0", pulses); end
        compared++; if (O !== 4'b0000) begin mismatched++; $display("FAIL idle_O got %b want 0000", O); end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] f;
        f = 4'b1010;
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 0), f[i]);
        compared++; if (O !== 4'b1010) begin mismatched++; $display("FAIL rmid_pre_O got %b want 1010", O); end
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compared++; if (O !== 4'b0000 || sel !== 2'd0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
            mismatched++; $display("FAIL rmid_async got O=%b sel=%0d ov=%b err=%b want 0/0/0/0", O, sel, out_valid, frame_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1);
        compared++; if (pulses !== 0 || sel !== 2'd0) begin mismatched++; $display("FAIL rmid_needs_start got ov=%0d sel=%0d want 0/0", pulses, sel); end
        f = 4'b1101;
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 0), f[i]);
        compared++; if (O !== 4'b1101 || out_valid !== 1'b1) begin mismatched++; $display("FAIL rmid_post got O=%b ov=%b want 1101/1", O, out_valid); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        pulses = 0;
        errs = 0;
        rst = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        frame_start = 1'b0;
        test_reset();
        test_single_frame();
        test_stall_free_run();
        test_back_to_back();
        test_misplaced_start();
        test_slot3_abort();
        test_idle_discard();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
